load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the ALU in the RV32I datapath. It takes the ALU result as the effective address of a load or store and runs the transfer on a valid/ready data-memory bus. It generates byte strobes and lane-replicated write data, and sign- or zero-extends load data for write-back. While the access is in flight it stalls the core, and it reports misaligned/illegal accesses and bus timeouts.

## Interface
- `TIMEOUT`, default 255: maximum REQ cycles before abort; 0 disables the timeout.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: load/store request from core; held stable while `stall`=1.
- `req_we` in 1: 1=store, 0=load.
- `req_funct3` in 3: RV32I funct3. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- `req_addr` in 32: effective address (ALU result).
- `req_wdata` in 32: store data (rs2).
- `stall` out 1: freeze the core PC/pipeline.
- `done` out 1: one-cycle completion pulse.
- `rdata` out 32: extended load result.
- `err_misaligned` out 1: misaligned or illegal access; valid with `done`.
- `err_timeout` out 1: bus timeout; valid with `done`.
- `mem_valid` out 1, `mem_ready` in 1: bus handshake.
- `mem_we` out 1, `mem_addr` out 32 (bits [1:0]=0), `mem_wstrb` out 4, `mem_wdata` out 32, `mem_rdata` in 32 (valid when `mem_valid & mem_ready & !mem_we`).

## Operation
- FSM states: IDLE, REQ, RESP.
- IDLE, `req_valid`=0: stay in IDLE.
- IDLE, `req_valid`=1: latch we/funct3/addr/wdata. If the access is legal and aligned → REQ; otherwise → RESP with the misaligned flag set.
- REQ: `mem_valid`=1, bus fields driven from the latched request.
  - `mem_valid & mem_ready` → RESP.
  - Timeout counter reaches `TIMEOUT` first → RESP with the timeout flag set. `mem_valid` drops and the transfer is abandoned.
- RESP: `done`=1; error flags reflect the latched cause; always → IDLE. `req_valid` is ignored in RESP because it still belongs to the retiring instruction.
- `stall` = (IDLE & `req_valid`) | REQ. Registered flags are 0 outside RESP.
- Illegal/misaligned: funct3 011/110/111; stores with funct3 100/101; half with addr[0]=1; word with addr[1:0]≠0. These never touch the bus.
- Strobes:
  - SB: 0001 << addr[1:0].
  - SH: 0011 << addr[1:0].
  - SW: 1111.
  - Loads drive 1111.
- Write data: SB replicates the byte ×4; SH replicates the half ×2; SW passes through.
- Load data is mem_rdata >> (8·addr[1:0]), truncated to 8/16/32 bits. LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- `rdata` is updated only on a successful load handshake. It is held otherwise, including on stores and errors.
- Timeout counter is $clog2(TIMEOUT+1) bits, cleared on entry to REQ. It saturates and never wraps.

## Timing
- Reset (async, immediate): state IDLE; `mem_valid`, `mem_we`, `done`, both error flags = 0; `mem_wstrb`=0; `mem_addr`, `mem_wdata`, `rdata` = 0.
- `stall` is combinational and is 1 during reset only if `req_valid`=1.
- Accepted aligned access with `mem_ready`=1 on the first REQ cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ, mem_valid=1.
  - cycle 2: RESP, done=1, stall=0.
  - Minimum latency is 2 stalled cycles. Each cycle of `mem_ready`=0 adds one.
- Misaligned access: 1 stalled cycle (IDLE), then RESP.
- Timeout: `err_timeout` asserts in the RESP cycle following the TIMEOUT-th REQ cycle without ready.
- Bus fields are stable for the whole REQ period. `mem_valid` never deasserts in REQ without a handshake or timeout.
- Reset asserted mid-REQ: `mem_valid` drops asynchronously, no `done` is produced, and the request is lost.
- `req_valid` is sampled only in IDLE. Back-to-back requests each cost the full sequence; there is no pipelining.

## Structure
- `lsu_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW) and the state enum `lsu_state_t` {IDLE, REQ, RESP}.
- Sub-module `load_extend` (combinational): inputs mem_rdata, addr[1:0], funct3; output the 32-bit extended value.
- Strobe/replication logic and the FSM live in the top module.

## Test plan
- SW 0xDEADBEEF @0x100, ready on first REQ cycle → mem_addr 0x100, wstrb 1111, wdata 0xDEADBEEF; done at cycle 2; stall high exactly cycles 0-1.
- SB 0x000000A5 @0x203 → wstrb 1000, wdata 0xA5A5A5A5. LB @0x203 with mem_rdata 0x80112233 → rdata 0xFFFFFF80. LBU at the same address → 0x00000080.
- LH @0x102 with mem_rdata 0x8001_7FFF → rdata 0xFFFF8001. LHU → 0x00008001. LH @0x101 → err_misaligned, mem_valid never asserts, rdata unchanged.
- TIMEOUT=4, mem_ready held 0 → mem_valid high 4 cycles, then RESP with err_timeout=1 and done=1; the next request proceeds normally.
- mem_ready delayed 3 cycles → stall held for 5 cycles, done single-cycle; rdata captures mem_rdata from the ready cycle only.
- rst_n pulled low during REQ → mem_valid=0 and all outputs at reset values immediately; after release the unit is in IDLE and no done pulse occurs.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I funct3 encodings,
// FSM state type and the access-legality check.
package lsu_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned STRB_W = XLEN / 8;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_t;

  // Legal encoding and natural alignment for the access size.
  function automatic logic access_ok(input logic we, input logic [2:0] f3,
                                     input logic [1:0] off);
    logic ok;
    ok = 1'b0;
    case (f3)
      LB:      ok = 1'b1;
      LH:      ok = ~off[0];
      LW:      ok = (off == 2'b00);
      LBU:     ok = ~we;
      LHU:     ok = ~we & ~off[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory valid/ready bus.
//   master: drives mem_valid/mem_we/mem_addr/mem_wstrb/mem_wdata,
//           receives mem_ready/mem_rdata.
//   slave : the memory side.
interface load_store_unit_if;
  import lsu_pkg::*;

  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [XLEN-1:0]   mem_addr;
  logic [STRB_W-1:0] mem_wstrb;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/load_extend.sv
// Load data alignment and sign/zero extension (combinational).
//   mem_rdata : raw word from the bus
//   off       : byte offset addr[1:0]
//   funct3    : load type
//   ext_c     : extended write-back value
module load_extend
  import lsu_pkg::*;
(
  input  logic [XLEN-1:0] mem_rdata,
  input  logic [1:0]      off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] ext_c
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    ext_c   = shifted;
    case (funct3)
      LB:      ext_c = {{24{shifted[7]}}, shifted[7:0]};
      LH:      ext_c = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     ext_c = {24'h0, shifted[7:0]};
      LHU:     ext_c = {16'h0, shifted[15:0]};
      default: ext_c = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: runs one load/store per request on the
// data-memory bus, stalls the core while in flight, extends load data,
// and flags misaligned/illegal accesses and bus timeouts.
//   clk, rst_n      : clock, async active-low reset
//   req_*           : request from the core (held while stall=1)
//   stall           : combinational pipeline freeze
//   done, err_*     : one-cycle completion pulse and its error cause
//   rdata           : last successful load result
//   mem             : data-memory bus (master side)
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [XLEN-1:0]          req_addr,
  input  logic [XLEN-1:0]          req_wdata,
  output logic                     stall,
  output logic                     done,
  output logic [XLEN-1:0]          rdata,
  output logic                     err_misaligned,
  output logic                     err_timeout,
  load_store_unit_if.master        mem
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  lsu_state_t        state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [STRB_W-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic              done_q, done_d;
  logic              err_mis_q, err_mis_d;
  logic              err_to_q, err_to_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [XLEN-1:0]   ext_c;
  logic [STRB_W-1:0] strb_c;
  logic [XLEN-1:0]   wdata_rep_c;
  logic [CNT_W-1:0]  cnt_inc_c;
  logic              cnt_sat_c;
  logic              timeout_hit_c;

  load_extend u_load_extend (
    .mem_rdata (mem.mem_rdata),
    .off       (off_q),
    .funct3    (f3_q),
    .ext_c     (ext_c)
  );

  // Byte strobes and lane replication from the incoming request.
  always_comb begin
    strb_c      = {STRB_W{1'b1}};
    wdata_rep_c = req_wdata;
    if (req_we) begin
      case (req_funct3)
        SB: begin
          strb_c      = 4'b0001 << req_addr[1:0];
          wdata_rep_c = {4{req_wdata[7:0]}};
        end
        SH: begin
          strb_c      = 4'b0011 << req_addr[1:0];
          wdata_rep_c = {2{req_wdata[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Saturating REQ-cycle counter; the abort fires on the cycle it would reach TIMEOUT.
  always_comb begin
    cnt_sat_c     = (cnt_q == {CNT_W{1'b1}});
    cnt_inc_c     = cnt_q + CNT_W'(1);
    timeout_hit_c = (TIMEOUT != 0) && !cnt_sat_c && (cnt_inc_c == CNT_W'(TIMEOUT));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    f3_d        = f3_q;
    off_d       = off_q;
    cnt_d       = cnt_q;
    mem_valid_d = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
    done_d      = 1'b0;
    err_mis_d   = 1'b0;
    err_to_d    = 1'b0;
    rdata_d     = rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (access_ok(req_we, req_funct3, req_addr[1:0])) begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            f3_d        = req_funct3;
            off_d       = req_addr[1:0];
            cnt_d       = '0;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
            mem_wstrb_d = strb_c;
            mem_wdata_d = wdata_rep_c;
          end else begin
            state_d   = RESP;
            done_d    = 1'b1;
            err_mis_d = 1'b1;
          end
        end
      end
      REQ: begin
        if (mem_valid_q && mem.mem_ready) begin
          state_d = RESP;
          done_d  = 1'b1;
          if (!mem_we_q) rdata_d = ext_c;
        end else if (timeout_hit_c) begin
          state_d  = RESP;
          done_d   = 1'b1;
          err_to_d = 1'b1;
        end else begin
          mem_valid_d = 1'b1;
          if (!cnt_sat_c) cnt_d = cnt_inc_c;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      f3_q        <= 3'b000;
      off_q       <= 2'b00;
      cnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_mis_q   <= 1'b0;
      err_to_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      cnt_q       <= cnt_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
      done_q      <= done_d;
      err_mis_q   <= err_mis_d;
      err_to_q    <= err_to_d;
      rdata_q     <= rdata_d;
    end
  end

  assign stall          = ((state_q == IDLE) && req_valid) || (state_q == REQ);
  assign done           = done_q;
  assign rdata          = rdata_q;
  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;
  assign mem.mem_valid  = mem_valid_q;
  assign mem.mem_we     = mem_we_q;
  assign mem.mem_addr   = mem_addr_q;
  assign mem.mem_wstrb  = mem_wstrb_q;
  assign mem.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit (TIMEOUT=4).
module tb_load_store_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        err_misaligned;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  load_store_unit_if mem_if ();

  load_store_unit #(.TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .stall          (stall),
    .done           (done),
    .rdata          (rdata),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout),
    .mem            (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] bus;
    int          delay;
    logic [31:0] e_addr;
    logic [3:0]  e_strb;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_mis;
    logic        e_to;
    int          e_lat;
    int          e_mv;
  } vec_t;

  vec_t vecs[15];

  function automatic vec_t mk(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] bus, input int delay,
                              input logic [31:0] e_addr, input logic [3:0] e_strb,
                              input logic [31:0] e_wdata, input logic [31:0] e_rdata,
                              input logic e_mis, input logic e_to,
                              input int e_lat, input int e_mv);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.bus = bus;
    v.delay = delay; v.e_addr = e_addr; v.e_strb = e_strb; v.e_wdata = e_wdata;
    v.e_rdata = e_rdata; v.e_mis = e_mis; v.e_to = e_to; v.e_lat = e_lat;
    v.e_mv = e_mv;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Runs one request from posedge+1 until done, checking each cycle.
  task automatic run_vec(input vec_t v, input string nm);
    int cyc, stall_cnt, mv_cnt;
    bit got_done;
    cyc = 0; stall_cnt = 0; mv_cnt = 0; got_done = 0;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    mem_if.mem_ready = 1'b0;
    while (!got_done && cyc < 40) begin
      #1;
      if (done) begin
        got_done = 1;
      end else begin
        if (stall) stall_cnt++;
        if (mem_if.mem_valid) begin
          mv_cnt++;
          chk({nm, "_addr"}, mem_if.mem_addr, v.e_addr);
          chk({nm, "_strb"}, 32'(mem_if.mem_wstrb), 32'(v.e_strb));
          chk({nm, "_we"}, 32'(mem_if.mem_we), 32'(v.we));
          if (v.we) chk({nm, "_wdata"}, mem_if.mem_wdata, v.e_wdata);
          mem_if.mem_ready = (mv_cnt > v.delay);
          mem_if.mem_rdata = mem_if.mem_ready ? v.bus : 32'hBAD0_BAD0;
        end else begin
          mem_if.mem_ready = 1'b0;
        end
        @(posedge clk);
        cyc++;
      end
    end
    chk({nm, "_done_seen"}, 32'(got_done), 32'd1);
    chk({nm, "_lat"}, 32'(cyc), 32'(v.e_lat));
    chk({nm, "_stall_cycles"}, 32'(stall_cnt), 32'(v.e_lat));
    chk({nm, "_mv_cycles"}, 32'(mv_cnt), 32'(v.e_mv));
    chk({nm, "_stall_in_resp"}, 32'(stall), 32'd0);
    chk({nm, "_err_mis"}, 32'(err_misaligned), 32'(v.e_mis));
    chk({nm, "_err_to"}, 32'(err_timeout), 32'(v.e_to));
    chk({nm, "_rdata"}, rdata, v.e_rdata);
    req_valid = 1'b0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk({nm, "_done_pulse"}, 32'(done), 32'd0);
    chk({nm, "_err_clear"}, 32'({err_misaligned, err_timeout}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rdata = 32'h0;

    vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 0, 2, 1);
    vecs[1]  = mk(1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h0, 0, 0, 2, 1);
    vecs[2]  = mk(0, 3'b000, 32'h203, 32'h0, 32'h80112233, 0, 32'h200, 4'b1111, 32'h0, 32'hFFFFFF80, 0, 0, 2, 1);
    vecs[3]  = mk(0, 3'b100, 32'h203, 32'h0, 32'h80112233, 0, 32'h200, 4'b1111, 32'h0, 32'h00000080, 0, 0, 2, 1);
    vecs[4]  = mk(0, 3'b001, 32'h102, 32'h0, 32'h80017FFF, 0, 32'h100, 4'b1111, 32'h0, 32'hFFFF8001, 0, 0, 2, 1);
    vecs[5]  = mk(0, 3'b101, 32'h102, 32'h0, 32'h80017FFF, 0, 32'h100, 4'b1111, 32'h0, 32'h00008001, 0, 0, 2, 1);
    vecs[6]  = mk(0, 3'b001, 32'h101, 32'h0, 32'h80017FFF, 0, 32'h0, 4'b0, 32'h0, 32'h00008001, 1, 0, 1, 0);
    vecs[7]  = mk(0, 3'b010, 32'h300, 32'h0, 32'h12345678, 3, 32'h300, 4'b1111, 32'h0, 32'h12345678, 0, 0, 5, 4);
    vecs[8]  = mk(1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 32'h300, 4'b1100, 32'hABCDABCD, 32'h12345678, 0, 0, 2, 1);
    vecs[9]  = mk(0, 3'b010, 32'h010, 32'h0, 32'h55555555, 99, 32'h010, 4'b1111, 32'h0, 32'h12345678, 0, 1, 5, 4);
    vecs[10] = mk(0, 3'b010, 32'h020, 32'h0, 32'hCAFEF00D, 0, 32'h020, 4'b1111, 32'h0, 32'hCAFEF00D, 0, 0, 2, 1);
    vecs[11] = mk(0, 3'b011, 32'h040, 32'h0, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'hCAFEF00D, 1, 0, 1, 0);
    vecs[12] = mk(1, 3'b100, 32'h040, 32'h11, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'hCAFEF00D, 1, 0, 1, 0);
    vecs[13] = mk(1, 3'b010, 32'h102, 32'h22, 32'h0, 0, 32'h0, 4'b0, 32'h0, 32'hCAFEF00D, 1, 0, 1, 0);
    vecs[14] = mk(0, 3'b000, 32'h001, 32'h0, 32'h00007F00, 0, 32'h000, 4'b1111, 32'h0, 32'h0000007F, 0, 0, 2, 1);

    // Reset values
    #12;
    chk("rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("rst_mem_we", 32'(mem_if.mem_we), 32'd0);
    chk("rst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    chk("rst_addr", mem_if.mem_addr, 32'h0);
    chk("rst_wdata", mem_if.mem_wdata, 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_done_err", 32'({done, err_misaligned, err_timeout}), 32'd0);
    chk("rst_stall_idle", 32'(stall), 32'd0);
    req_valid = 1'b1;
    #1;
    chk("rst_stall_req", 32'(stall), 32'd1);
    req_valid = 1'b0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a REQ
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h400; req_wdata = 32'h0;
    mem_if.mem_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_in_req", 32'(mem_if.mem_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_valid", 32'(mem_if.mem_valid), 32'd0);
    chk("mid_rst_wstrb", 32'(mem_if.mem_wstrb), 32'd0);
    chk("mid_rst_addr", mem_if.mem_addr, 32'h0);
    chk("mid_rst_rdata", rdata, 32'h0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_stall_req", 32'(stall), 32'd1);
    req_valid = 1'b0;
    #1;
    chk("mid_rst_stall_idle", 32'(stall), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_no_done_%0d", k), 32'(done), 32'd0);
      chk($sformatf("post_rst_idle_%0d", k), 32'(mem_if.mem_valid), 32'd0);
    end

    run_vec(mk(0, 3'b001, 32'h502, 32'h0, 32'h7ABC0000, 1, 32'h500, 4'b1111, 32'h0,
               32'h00007ABC, 0, 0, 3, 2), "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
